// File: rtl/roc_bnk_ctrl.sv
// rtl/roc_bnk_ctrl.sv - ring-oscillator bank sequencer: warm-up, sampling, word packing, stuck test
// Latches the challenge pair, enables the bank, packs XOR-compressed RO samples into words.
module roc_bnk_ctrl #(
  parameter int WARM_CYC   = 64,
  parameter int SAMPLE_DIV = 16,
  parameter int OUT_W      = 8,
  parameter int STUCK_LIM  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic [7:0]       cnf1_i,
  input  logic [7:0]       cnf2_i,
  input  logic             clr_alarm_i,
  output logic             enx,
  output logic             eny,
  output logic [7:0]       cnf1,
  output logic [7:0]       cnf2,
  input  logic [3:0]       ro,
  output logic [OUT_W-1:0] rnd_o,
  output logic             rnd_valid_o,
  input  logic             rnd_ready_i,
  output logic             busy_o,
  output logic             alarm_o
);

  localparam int WW = $clog2(WARM_CYC + 1);
  localparam int DW = $clog2(SAMPLE_DIV + 1);
  localparam int BW = $clog2(OUT_W + 1);
  localparam int SW = $clog2(STUCK_LIM + 1);

  localparam logic [WW-1:0] WARM_LAST = WW'(WARM_CYC - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(OUT_W - 1);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_LIM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WARM,
    S_SAMPLE,
    S_OUTPUT,
    S_ALARM
  } state_t;

  state_t        state;
  logic [WW-1:0] warm_cnt;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] stuck_cnt;
  logic [SW-1:0] stuck_nxt;
  logic [3:0]    ro_meta;
  logic [3:0]    ro_sync;
  logic [3:0]    prev;
  logic          en_q;

  assign enx = en_q;
  assign eny = en_q;

  // Saturating run length of identical synchronised samples.
  always_comb begin
    stuck_nxt = '0;
    if (ro_sync == prev)
      stuck_nxt = (stuck_cnt == STUCK_MAX) ? STUCK_MAX : stuck_cnt + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      warm_cnt    <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      stuck_cnt   <= '0;
      ro_meta     <= '0;
      ro_sync     <= '0;
      prev        <= '0;
      en_q        <= 1'b0;
      cnf1        <= '0;
      cnf2        <= '0;
      rnd_o       <= '0;
      rnd_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      alarm_o     <= 1'b0;
    end else begin
      ro_meta <= ro;
      ro_sync <= ro_meta;
      case (state)
        S_IDLE: begin
          if (run_i) begin
            state  <= S_SETUP;
            busy_o <= 1'b1;
          end
        end
        S_SETUP: begin
          cnf1      <= cnf1_i;
          cnf2      <= cnf2_i;
          warm_cnt  <= '0;
          div_cnt   <= '0;
          bit_cnt   <= '0;
          stuck_cnt <= '0;
          en_q      <= 1'b1;
          state     <= S_WARM;
        end
        S_WARM: begin
          if (!run_i) begin
            state  <= S_IDLE;
            en_q   <= 1'b0;
            busy_o <= 1'b0;
          end else if (warm_cnt == WARM_LAST) begin
            state   <= S_SAMPLE;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            warm_cnt <= warm_cnt + WW'(1);
          end
        end
        S_SAMPLE: begin
          if (!run_i) begin
            state  <= S_IDLE;
            en_q   <= 1'b0;
            busy_o <= 1'b0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            prev      <= ro_sync;
            stuck_cnt <= stuck_nxt;
            rnd_o     <= {rnd_o[OUT_W-2:0], ^ro_sync};
            // A trip on the word-completing tick takes precedence over presenting the word.
            if (stuck_nxt == STUCK_MAX) begin
              state   <= S_ALARM;
              en_q    <= 1'b0;
              busy_o  <= 1'b0;
              alarm_o <= 1'b1;
            end else if (bit_cnt == BIT_LAST) begin
              state       <= S_OUTPUT;
              bit_cnt     <= '0;
              rnd_valid_o <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_OUTPUT: begin
          if (rnd_ready_i) begin
            rnd_valid_o <= 1'b0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            if (run_i) begin
              state <= S_SAMPLE;
            end else begin
              state  <= S_IDLE;
              en_q   <= 1'b0;
              busy_o <= 1'b0;
            end
          end
        end
        S_ALARM: begin
          if (clr_alarm_i) begin
            state   <= S_IDLE;
            alarm_o <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          en_q        <= 1'b0;
          busy_o      <= 1'b0;
          rnd_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_roc_bnk_ctrl.sv
// tb/tb_roc_bnk_ctrl.sv - self-checking bench for roc_bnk_ctrl
// Stimulus is randomised; expected words and timings come from the sequencer's timing rules.
module tb_roc_bnk_ctrl;

  localparam int WARM_CYC   = 64;
  localparam int SAMPLE_DIV = 16;
  localparam int OUT_W      = 8;
  localparam int STUCK_LIM  = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run_i = 1'b0;
  logic [7:0] cnf1_i = '0;
  logic [7:0] cnf2_i = '0;
  logic       clr_alarm_i = 1'b0;
  logic       enx, eny;
  logic [7:0] cnf1, cnf2;
  logic [3:0] ro = '0;
  logic [OUT_W-1:0] rnd_o;
  logic       rnd_valid_o;
  logic       rnd_ready_i = 1'b0;
  logic       busy_o, alarm_o;

  int n_cmp = 0;
  int n_err = 0;

  roc_bnk_ctrl #(
    .WARM_CYC(WARM_CYC), .SAMPLE_DIV(SAMPLE_DIV), .OUT_W(OUT_W), .STUCK_LIM(STUCK_LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .cnf1_i(cnf1_i), .cnf2_i(cnf2_i),
    .clr_alarm_i(clr_alarm_i), .enx(enx), .eny(eny), .cnf1(cnf1), .cnf2(cnf2),
    .ro(ro), .rnd_o(rnd_o), .rnd_valid_o(rnd_valid_o), .rnd_ready_i(rnd_ready_i),
    .busy_o(busy_o), .alarm_o(alarm_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Drives one word's worth of RO values, each settled half a sample period before its tick.
  // Ends right after the tick that completes the word.
  task automatic sample_word(input bit use_pat, input logic [7:0] pat, output logic [7:0] exp);
    logic [3:0] r;
    exp = '0;
    for (int i = 0; i < OUT_W; i++) begin
      repeat (SAMPLE_DIV / 2) step();
      r = 4'($urandom);
      if (use_pat && ((^r) != pat[OUT_W-1-i])) r = r ^ 4'h1;
      ro = r;
      exp = {exp[6:0], ^r};
      if (i == OUT_W - 1) begin
        repeat (SAMPLE_DIV / 2 - 1) step();
        n_cmp++;
        if (rnd_valid_o !== 1'b0) begin
          n_err++; $display("FAIL early_valid got=%b want=0", rnd_valid_o);
        end
        step();
      end else begin
        repeat (SAMPLE_DIV / 2) step();
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({enx, eny, cnf1, cnf2, rnd_o, rnd_valid_o, busy_o, alarm_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h want=0",
               {enx, eny, cnf1, cnf2, rnd_o, rnd_valid_o, busy_o, alarm_o});
    end
  endtask

  task automatic test_first_word();
    logic [7:0] exp;
    cnf1_i = 8'hA5; cnf2_i = 8'h3C; rnd_ready_i = 1'b0;
    run_i = 1'b1;
    step();
    n_cmp++;
    if (busy_o !== 1'b1) begin n_err++; $display("FAIL t1_busy got=%b want=1", busy_o); end
    step();
    cnf1_i = 8'h00; cnf2_i = 8'hFF;
    n_cmp++;
    if ({enx, eny} !== 2'b11) begin n_err++; $display("FAIL t1_enables got=%b want=11", {enx, eny}); end
    n_cmp++;
    if ({cnf1, cnf2} !== 16'hA53C) begin n_err++; $display("FAIL t1_cnf got=%h want=a53c", {cnf1, cnf2}); end
    repeat (WARM_CYC) step();
    sample_word(1'b0, 8'h00, exp);
    n_cmp++;
    if (rnd_valid_o !== 1'b1 || rnd_o !== exp) begin
      n_err++; $display("FAIL t1_word valid=%b rnd=%h want valid=1 rnd=%h", rnd_valid_o, rnd_o, exp);
    end
    n_cmp++;
    if ({cnf1, cnf2} !== 16'hA53C) begin n_err++; $display("FAIL t1_cnf_hold got=%h want=a53c", {cnf1, cnf2}); end
    rnd_ready_i = 1'b1;
    step();
    n_cmp++;
    if (rnd_valid_o !== 1'b0) begin n_err++; $display("FAIL t1_handshake got=%b want=0", rnd_valid_o); end
  endtask

  task automatic test_pattern();
    logic [7:0] exp;
    sample_word(1'b1, 8'hB2, exp);
    n_cmp++;
    if (rnd_valid_o !== 1'b1 || rnd_o !== 8'hB2) begin
      n_err++; $display("FAIL t2_pattern valid=%b rnd=%h want valid=1 rnd=b2", rnd_valid_o, rnd_o);
    end
    step();
    n_cmp++;
    if (rnd_valid_o !== 1'b0 || enx !== 1'b1) begin
      n_err++; $display("FAIL t2_one_valid valid=%b enx=%b want valid=0 enx=1", rnd_valid_o, enx);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    rnd_ready_i = 1'b0;
    sample_word(1'b0, 8'h00, exp);
    n_cmp++;
    if (rnd_valid_o !== 1'b1 || rnd_o !== exp) begin
      n_err++; $display("FAIL t3_next_word valid=%b rnd=%h want valid=1 rnd=%h", rnd_valid_o, rnd_o, exp);
    end
    for (int c = 0; c < 50; c++) begin
      if (c == 20) run_i = 1'b0;
      ro = 4'($urandom);
      step();
      n_cmp++;
      if (rnd_valid_o !== 1'b1 || rnd_o !== exp) begin
        n_err++; $display("FAIL t3_stable cyc=%0d valid=%b rnd=%h want valid=1 rnd=%h", c, rnd_valid_o, rnd_o, exp);
      end
    end
    rnd_ready_i = 1'b1;
    step();
    n_cmp++;
    if ({rnd_valid_o, enx, eny, busy_o} !== 4'b0000) begin
      n_err++; $display("FAIL t3_idle got=%b want=0000", {rnd_valid_o, enx, eny, busy_o});
    end
  endtask

  task automatic test_stuck_alarm();
    int rise;
    int exp_rise;
    ro = 4'h0;
    rnd_ready_i = 1'b1;
    run_i = 1'b0;
    do_reset();
    // Every complete word before the trip costs one extra OUTPUT cycle.
    exp_rise = 1 + WARM_CYC + STUCK_LIM * SAMPLE_DIV + (STUCK_LIM - 1) / OUT_W;
    rise = -1;
    run_i = 1'b1;
    step();
    for (int e = 1; e <= 1000; e++) begin
      step();
      if (alarm_o === 1'b1) begin rise = e; break; end
    end
    n_cmp++;
    if (rise != exp_rise) begin n_err++; $display("FAIL t4_alarm_cycle got=%0d want=%0d", rise, exp_rise); end
    n_cmp++;
    if ({enx, eny, rnd_valid_o, busy_o} !== 4'b0000) begin
      n_err++; $display("FAIL t4_safe got=%b want=0000", {enx, eny, rnd_valid_o, busy_o});
    end
    repeat (3) step();
    n_cmp++;
    if (alarm_o !== 1'b1) begin n_err++; $display("FAIL t4_alarm_hold got=%b want=1", alarm_o); end
    clr_alarm_i = 1'b1;
    step();
    clr_alarm_i = 1'b0;
    n_cmp++;
    if ({alarm_o, busy_o, enx} !== 3'b000) begin
      n_err++; $display("FAIL t4_clear got=%b want=000", {alarm_o, busy_o, enx});
    end
    step();
    n_cmp++;
    if ({busy_o, enx} !== 2'b10) begin n_err++; $display("FAIL t4_setup got=%b want=10", {busy_o, enx}); end
    step();
    n_cmp++;
    if ({busy_o, enx, eny} !== 3'b111) begin n_err++; $display("FAIL t4_warm got=%b want=111", {busy_o, enx, eny}); end
  endtask

  task automatic test_run_drop();
    logic [7:0] exp;
    logic [7:0] c1, c2;
    run_i = 1'b0;
    rnd_ready_i = 1'b0;
    do_reset();
    c1 = 8'($urandom); c2 = 8'($urandom);
    cnf1_i = c1; cnf2_i = c2;
    run_i = 1'b1;
    step();
    step();
    repeat (WARM_CYC) step();
    for (int i = 0; i < 5 * SAMPLE_DIV; i++) begin
      ro = 4'($urandom);
      step();
    end
    run_i = 1'b0;
    step();
    n_cmp++;
    if ({busy_o, enx, eny, rnd_valid_o} !== 4'b0000) begin
      n_err++; $display("FAIL t5_drop got=%b want=0000", {busy_o, enx, eny, rnd_valid_o});
    end
    c1 = ~c1 ^ 8'($urandom_range(1, 255)); c2 = c2 + 8'd77;
    cnf1_i = c1; cnf2_i = c2;
    run_i = 1'b1;
    step();
    step();
    cnf1_i = ~c1; cnf2_i = ~c2;
    n_cmp++;
    if ({cnf1, cnf2} !== {c1, c2}) begin
      n_err++; $display("FAIL t5_new_cnf got=%h want=%h", {cnf1, cnf2}, {c1, c2});
    end
    repeat (WARM_CYC) step();
    n_cmp++;
    if ({cnf1, cnf2} !== {c1, c2}) begin
      n_err++; $display("FAIL t5_cnf_ignored got=%h want=%h", {cnf1, cnf2}, {c1, c2});
    end
    sample_word(1'b0, 8'h00, exp);
    n_cmp++;
    if (rnd_valid_o !== 1'b1 || rnd_o !== exp) begin
      n_err++; $display("FAIL t5_word valid=%b rnd=%h want valid=1 rnd=%h", rnd_valid_o, rnd_o, exp);
    end
  endtask

  task automatic test_async_reset();
    rnd_ready_i = 1'b1;
    step();
    repeat (20) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({enx, eny, cnf1, cnf2, rnd_o, rnd_valid_o, busy_o, alarm_o} !== '0) begin
      n_err++;
      $display("FAIL t6_async got=%h want=0",
               {enx, eny, cnf1, cnf2, rnd_o, rnd_valid_o, busy_o, alarm_o});
    end
    run_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    n_cmp++;
    if ({busy_o, enx, rnd_valid_o, alarm_o} !== 4'b0000) begin
      n_err++; $display("FAIL t6_idle got=%b want=0000", {busy_o, enx, rnd_valid_o, alarm_o});
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_pattern();
    test_backpressure();
    test_stuck_alarm();
    test_run_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
